// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, with start/busy/done control.
// Optional macro SUB_OVF_FLAG_EN adds the ovf_out signed-overflow flag.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
`ifdef SUB_OVF_FLAG_EN
  output logic             ovf_out,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: start is accepted only in IDLE (busy=0); busy stays high through
  // SHIFT and DONE; done pulses for one cycle and diff_out/borrow_out are valid
  // from that cycle until the next completed operation.
  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             w_d;
  logic             w_bout;
  logic             w_last;

  // 1-bit full-subtract cell fed by the low operand bits and the stored borrow
  assign w_d    = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
  assign w_bout = (~r_a_sh[0] & (r_b_sh[0] | r_borrow)) | (r_b_sh[0] & r_borrow);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_d_sh     <= '0;
      r_cnt      <= '0;
      r_borrow   <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= a_in;
            r_b_sh   <= b_in;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_d_sh   <= {w_d, r_d_sh[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            diff_out   <= {w_d, r_d_sh[WIDTH-1:1]};
            borrow_out <= w_bout;
`ifdef SUB_OVF_FLAG_EN
            // borrow into the MSB (still in r_borrow) vs borrow out of it
            ovf_out    <= r_borrow ^ w_bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
